// File: rtl/agu_nd.sv
// N-deep nested-loop address generator with valid/ready output, counted or infinite outer loop.
// Define AGU_WRAP_EN to add a wrap_len port that folds the running offset into [0, wrap_len).
module agu_nd #(
    parameter int BWADDR   = 21,
    parameter int BWLENGTH = 8,
    parameter int NLOOPS   = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           start,
    input  logic                           abort,
    input  logic [BWADDR-1:0]              base,
`ifdef AGU_WRAP_EN
    input  logic [BWADDR-1:0]              wrap_len,
`endif
    input  logic [NLOOPS:0][BWADDR-1:0]    j,
    input  logic [NLOOPS:1][BWLENGTH-1:0]  l,
    input  logic [BWLENGTH-1:0]            l0,
    output logic [BWADDR-1:0]              addr,
    output logic                           addr_valid,
    input  logic                           addr_ready,
    output logic                           addr_last,
    output logic [NLOOPS:0]                on_j,
    output logic [NLOOPS-1:0]              z_out,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state;
    state_t                        state_next;
    logic [NLOOPS:0][BWADDR-1:0]   j_r;
    logic [NLOOPS:1][BWLENGTH-1:0] l_r;
    logic [BWLENGTH-1:0]           l0_r;
    logic [BWLENGTH-1:0]           o;
    logic [BWLENGTH-1:0]           i [1:NLOOPS];
    int                            lvl;
    logic [BWADDR-1:0]             jump;
    logic [BWADDR-1:0]             addr_next;
    logic                          xfer;
    logic                          load;

    assign addr_valid = (state == RUN);
    assign busy       = (state == RUN);
    assign xfer       = addr_valid & addr_ready;
    assign load       = (state == IDLE) & start;

    // The innermost level whose counter has not run out owns the next jump.
    always_comb begin
        lvl = 0;
        for (int k = 1; k <= NLOOPS; k++) begin
            if (i[k] != '0) lvl = k;
        end
    end

    always_comb begin
        jump  = '0;
        on_j  = '0;
        z_out = '0;
        for (int k = 0; k <= NLOOPS; k++) begin
            if (lvl == k) jump = j_r[k];
            on_j[k] = addr_valid && (lvl == k);
        end
        for (int k = 1; k <= NLOOPS; k++) begin
            z_out[k-1] = addr_valid && (i[k] == '0);
        end
        addr_last = addr_valid && (l0_r != '0) && (o == BWLENGTH'(1)) && (lvl == 0);
    end

`ifdef AGU_WRAP_EN
    logic [BWADDR-1:0]        base_r;
    logic [BWADDR-1:0]        wrap_r;
    logic [BWADDR-1:0]        off;
    logic [BWADDR-1:0]        off_next;
    logic signed [BWADDR+1:0] off_sum;

    // Two guard bits keep off + signed jump exact before the single fold.
    always_comb begin
        off_sum  = $signed({2'b00, off}) + $signed({{2{jump[BWADDR-1]}}, jump});
        off_next = off_sum[BWADDR-1:0];
        if (wrap_r != '0) begin
            if (off_sum[BWADDR+1])
                off_next = off_sum[BWADDR-1:0] + wrap_r;
            else if (off_sum >= $signed({2'b00, wrap_r}))
                off_next = off_sum[BWADDR-1:0] - wrap_r;
        end
        addr_next = base_r + off_next;
    end
`else
    assign addr_next = addr + jump;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (abort || (xfer && addr_last)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            addr <= '0;
            done <= 1'b0;
            j_r  <= '0;
            l_r  <= '0;
            l0_r <= '0;
            o    <= '0;
            for (int k = 1; k <= NLOOPS; k++) i[k] <= '0;
`ifdef AGU_WRAP_EN
            base_r <= '0;
            wrap_r <= '0;
            off    <= '0;
`endif
        end else begin
            done <= (state == RUN) && (state_next == IDLE);
            if (load) begin
                addr <= base;
                j_r  <= j;
                l_r  <= l;
                l0_r <= l0;
                o    <= l0;
                for (int k = 1; k <= NLOOPS; k++) i[k] <= l[k];
`ifdef AGU_WRAP_EN
                base_r <= base;
                wrap_r <= wrap_len;
                off    <= '0;
`endif
            end else if (xfer) begin
                addr <= addr_next;
                // Levels inside the jumping one restart; level 0 restarts everything.
                for (int k = 1; k <= NLOOPS; k++) begin
                    if (k > lvl)       i[k] <= l_r[k];
                    else if (k == lvl) i[k] <= i[k] - 1'b1;
                end
                if (lvl == 0 && l0_r != '0) o <= o - 1'b1;
`ifdef AGU_WRAP_EN
                off <= off_next;
`endif
            end
        end
    end

endmodule
